fir_pair_serializer: RTL and testbench

- Output stage directly downstream of the two-parallel FIR.
- Accepts one even/odd result pair per handshake, already scaled by the filter. Saturates each 64-bit signed sample to OUT_W bits and buffers pairs in a small FIFO.
- Re-serializes the pairs into one sample per cycle on a valid/ready stream: even sample first, then odd.
- Keeps a saturation event counter for debug.

---
 rtl/fir_pair_serializer.sv | 167 ++++++++++++++++
 tb/tb_fir_pair_serializer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_pair_serializer.sv
// Output stage behind the two-parallel FIR. It saturates each incoming 64-bit even/odd
// pair to OUT_W bits, buffers the pairs in a small FIFO and re-serializes them as one
// sample per cycle (even first, then odd) on a valid/ready stream. It also keeps a
// sticky saturation event counter for debug.
module fir_pair_serializer #(
  parameter int unsigned IN_W  = 64,
  parameter int unsigned OUT_W = 16,
  parameter int unsigned DEPTH = 4,   // pairs; power of 2, >= 2
  parameter int unsigned CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  in_even,
  input  logic signed [IN_W-1:0]  in_odd,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_odd,
  output logic [CNT_W-1:0]        sat_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);

  // Returns {saturated_flag, clamped_value}. The value fits when every bit from the
  // sign bit down to bit OUT_W-1 matches the sign.
  function automatic logic [OUT_W:0] saturate(input logic [IN_W-1:0] v);
    logic fits;
    fits = (v[IN_W-1:OUT_W-1] == {(IN_W-OUT_W+1){v[IN_W-1]}});
    if (fits) begin
      return {1'b0, v[OUT_W-1:0]};
    end else if (v[IN_W-1]) begin
      return {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      return {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
    end
  endfunction

  logic [OUT_W:0]         sat_even;
  logic [OUT_W:0]         sat_odd;
  logic [2*OUT_W-1:0]     mem_q [DEPTH];
  logic [2*OUT_W-1:0]     head;

  logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]        count_q, count_d;
  logic                   sel_q, sel_d;
  logic                   in_ready_q, in_ready_d;
  logic                   out_valid_q, out_valid_d;
  logic [OUT_W-1:0]       out_data_q, out_data_d;
  logic                   out_odd_q, out_odd_d;
  logic [CNT_W-1:0]       sat_count_q, sat_count_d;

  logic                   push;
  logic                   pop;
  logic                   load;
  logic [CNT_W:0]         sat_sum;

  // Input saturation, ahead of storage
  always_comb begin
    sat_even = saturate(in_even);
    sat_odd  = saturate(in_odd);
  end

  assign head = mem_q[rd_ptr_q];
  // A flush discards a concurrent push; in_ready comes from the registered count only
  assign push = in_valid & in_ready_q & ~flush;
  assign load = (~out_valid_q | out_ready) & (count_q != '0);

  // Saturating add of 0, 1 or 2 saturation events
  always_comb begin
    sat_sum = {1'b0, sat_count_q} + (CNT_W+1)'(sat_even[OUT_W]) + (CNT_W+1)'(sat_odd[OUT_W]);
  end

  // Next-state logic for FIFO pointers, serializer select and output register
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    sel_d       = sel_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_odd_d   = out_odd_q;
    sat_count_d = sat_count_q;
    pop         = 1'b0;

    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      sel_d       = 1'b0;
      out_valid_d = 1'b0;
      out_odd_d   = 1'b0;
    end else begin
      if (load) begin
        out_valid_d = 1'b1;
        if (!sel_q) begin
          out_data_d = head[OUT_W-1:0];
          out_odd_d  = 1'b0;
          sel_d      = 1'b1;
        end else begin
          out_data_d = head[2*OUT_W-1:OUT_W];
          out_odd_d  = 1'b1;
          sel_d      = 1'b0;
          pop        = 1'b1;
        end
      end else if (!out_valid_q || out_ready) begin
        // Consumer took the last sample and nothing is buffered
        out_valid_d = 1'b0;
      end

      if (push) begin
        wr_ptr_d    = wr_ptr_q + PtrW'(1);
        sat_count_d = sat_sum[CNT_W] ? {CNT_W{1'b1}} : sat_sum[CNT_W-1:0];
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      count_d = count_q + CntW'(push) - CntW'(pop);
    end

    in_ready_d = (count_d != DepthC);
  end

  // Control and output state; in_ready stays low until the first clock after reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      sel_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_odd_q   <= 1'b0;
      sat_count_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      sel_q       <= sel_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_odd_q   <= out_odd_d;
      sat_count_q <= sat_count_d;
    end
  end

  // Pair storage; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {sat_odd[OUT_W-1:0], sat_even[OUT_W-1:0]};
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_odd   = out_odd_q;
  assign sat_count = sat_count_q;

endmodule

// File: tb/tb_fir_pair_serializer.sv
// Directed and randomized checks for fir_pair_serializer.
module tb_fir_pair_serializer;

  logic               clk;
  logic               rst;
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic signed [63:0] in_even;
  logic signed [63:0] in_odd;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_data;
  logic               out_odd;
  logic [15:0]        sat_count;

  int tests = 0;
  int fails = 0;
  int exp_sat = 0;

  fir_pair_serializer #(
    .IN_W (64),
    .OUT_W(16),
    .DEPTH(4),
    .CNT_W(16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_even  (in_even),
    .in_odd   (in_odd),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_odd  (out_odd),
    .sat_count(sat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [16:0] ref_sat(input longint v);
    if (v > 64'sd32767) return {1'b1, 16'h7fff};
    if (v < -64'sd32768) return {1'b1, 16'h8000};
    return {1'b0, v[15:0]};
  endfunction

  function automatic longint gen_val();
    longint b [6];
    b = '{64'sd32767, -64'sd32768, 64'sd32768, -64'sd32769, 64'sd0, -64'sd1};
    case ($urandom_range(0, 4))
      0: return longint'($urandom_range(0, 80000)) - 64'sd40000;
      1: return {$urandom, $urandom};
      2: return b[$urandom_range(0, 5)];
      3: return longint'($urandom_range(0, 200)) - 64'sd100;
      default: return -longint'($urandom_range(0, 1000000)) - 64'sd32000;
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_even = '0; in_odd = '0; out_ready = 1'b0;
    tick(); tick();
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    tests++; if (out_data !== 16'sd0) begin fails++; $display("FAIL reset_out_data got=%0d exp=0", out_data); end
    tests++; if (out_odd !== 1'b0) begin fails++; $display("FAIL reset_out_odd got=%b exp=0", out_odd); end
    tests++; if (sat_count !== 16'd0) begin fails++; $display("FAIL reset_sat_count got=%0d exp=0", sat_count); end
    rst = 1'b1;
    tick();
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_release_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    in_valid = 1'b1; in_even = 64'sd100; in_odd = -64'sd200;
    tick();
    in_valid = 1'b0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL single_T0_valid got=%b exp=0", out_valid); end
    tick();
    tests++; if (out_valid !== 1'b1 || out_data !== 16'sd100 || out_odd !== 1'b0) begin
      fails++; $display("FAIL single_even got v=%b d=%0d o=%b exp v=1 d=100 o=0", out_valid, out_data, out_odd); end
    tick();
    tests++; if (out_valid !== 1'b1 || out_data !== -16'sd200 || out_odd !== 1'b1) begin
      fails++; $display("FAIL single_odd got v=%b d=%0d o=%b exp v=1 d=-200 o=1", out_valid, out_data, out_odd); end
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL single_idle got=%b exp=0", out_valid); end
    tests++; if (sat_count !== 16'd0) begin fails++; $display("FAIL single_sat got=%0d exp=0", sat_count); end
  endtask

  task automatic test_saturate();
    logic signed [15:0] ed [4];
    ed = '{16'sd32767, -16'sd32768, 16'sd32767, -16'sd32768};
    out_ready = 1'b1;
    in_valid = 1'b1; in_even = 64'sd40000; in_odd = -64'sd70000;
    tick();
    exp_sat += 2;
    tests++; if (sat_count !== 16'd2) begin fails++; $display("FAIL sat_count_clamp got=%0d exp=2", sat_count); end
    in_even = 64'sd32767; in_odd = -64'sd32768;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tests++; if (out_valid !== 1'b1 || out_data !== ed[k] || out_odd !== k[0]) begin
        fails++; $display("FAIL sat_seq%0d got v=%b d=%0d o=%b exp d=%0d o=%b", k, out_valid, out_data,
                          out_odd, ed[k], k[0]); end
      tick();
    end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL sat_idle got=%b exp=0", out_valid); end
    tests++; if (sat_count !== 16'd2) begin fails++; $display("FAIL sat_count_edge got=%0d exp=2", sat_count); end
  endtask

  // Fill the FIFO with out_ready low; returns after 4 pairs are stored and e0 is shown
  task automatic fill_four(input int base);
    int idx;
    idx = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1;
      in_even = 64'(base + idx); in_odd = -64'(base + idx);
      if (in_ready) idx++;
      tick();
      tests++; if (in_ready !== (c < 3)) begin
        fails++; $display("FAIL fill_ready_c%0d got=%b exp=%b", c, in_ready, (c < 3)); end
      if (c >= 1) begin
        tests++; if (out_valid !== 1'b1 || out_data !== 16'(base)) begin
          fails++; $display("FAIL fill_hold_c%0d got v=%b d=%0d exp v=1 d=%0d", c, out_valid, out_data, base); end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain_eight(input int base, input string name);
    int v;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      v = k[0] ? -(base + k / 2) : (base + k / 2);
      tests++; if (out_valid !== 1'b1 || out_data !== 16'(v) || out_odd !== k[0]) begin
        fails++; $display("FAIL %s_s%0d got v=%b d=%0d o=%b exp d=%0d o=%b", name, k, out_valid,
                          out_data, out_odd, v, k[0]); end
      tick();
    end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL %s_idle got=%b exp=0", name, out_valid); end
  endtask

  task automatic test_backpressure();
    fill_four(1000);
    drain_eight(1000, "bp_drain");
  endtask

  task automatic test_full_pop_push();
    fill_four(2000);
    out_ready = 1'b1;
    in_valid = 1'b1; in_even = 64'sd2004; in_odd = -64'sd2004;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL full_refuse got=%b exp=0", in_ready); end
    tick();
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL full_reopen got=%b exp=1", in_ready); end
    tests++; if (out_data !== -16'sd2000 || out_odd !== 1'b1) begin
      fails++; $display("FAIL full_odd0 got d=%0d o=%b exp d=-2000 o=1", out_data, out_odd); end
    tick();
    in_valid = 1'b0;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL full_again got=%b exp=0", in_ready); end
    drain_eight(2001, "full_drain");
  endtask

  task automatic test_random();
    logic [16:0] exp_q [$];
    logic [16:0] se, so, e;
    logic        held, held_odd, accepted;
    logic [15:0] held_data;
    int          sent, cyc;
    sent = 0; cyc = 0; held = 1'b0; held_odd = 1'b0; held_data = '0;
    in_valid = 1'b0;
    while ((sent < 1000 || exp_q.size() != 0 || out_valid) && cyc < 20000) begin
      if (held) begin
        tests++; if (out_valid !== 1'b1 || out_data !== held_data || out_odd !== held_odd) begin
          fails++; $display("FAIL rnd_hold cyc=%0d got v=%b d=%0d exp d=%0d", cyc, out_valid, out_data,
                            $signed(held_data)); end
      end
      if (sent < 1000 && !in_valid && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1; in_even = gen_val(); in_odd = gen_val();
      end
      out_ready = ($urandom_range(0, 2) != 0);
      accepted = in_valid && in_ready;
      if (accepted) begin
        se = ref_sat(in_even); so = ref_sat(in_odd);
        exp_q.push_back({1'b0, se[15:0]});
        exp_q.push_back({1'b1, so[15:0]});
        exp_sat += int'(se[16]) + int'(so[16]);
        if (exp_sat > 65535) exp_sat = 65535;
        sent++;
      end
      if (out_valid && out_ready) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++; $display("FAIL rnd_extra got d=%0d exp none", out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e[15:0] || out_odd !== e[16]) begin
            fails++; $display("FAIL rnd_data got d=%0d o=%b exp d=%0d o=%b", out_data, out_odd,
                              $signed(e[15:0]), e[16]); end
        end
      end
      held = out_valid && !out_ready; held_data = out_data; held_odd = out_odd;
      tick();
      cyc++;
      if (accepted) in_valid = 1'b0;
    end
    tests++; if (cyc >= 20000) begin fails++; $display("FAIL rnd_timeout sent=%0d left=%0d exp done", sent, exp_q.size()); end
    tests++; if (sat_count !== 16'(exp_sat)) begin
      fails++; $display("FAIL rnd_sat_count got=%0d exp=%0d", sat_count, exp_sat); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_even = 64'sd50000; in_odd = -64'sd5;
    tick();
    exp_sat += 1;
    in_even = 64'sd6; in_odd = 64'sd7;
    tick();
    tests++; if (out_valid !== 1'b1 || out_data !== 16'sd32767) begin
      fails++; $display("FAIL flush_pre got v=%b d=%0d exp v=1 d=32767", out_valid, out_data); end
    flush = 1'b1; in_even = 64'sd90000; in_odd = 64'sd9;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    tests++; if (out_valid !== 1'b0 || out_odd !== 1'b0) begin
      fails++; $display("FAIL flush_out got v=%b o=%b exp v=0 o=0", out_valid, out_odd); end
    tests++; if (sat_count !== 16'(exp_sat)) begin
      fails++; $display("FAIL flush_sat got=%0d exp=%0d", sat_count, exp_sat); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL flush_ready got=%b exp=1", in_ready); end
    out_ready = 1'b1;
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_empty got=%b exp=0", out_valid); end
    in_valid = 1'b1; in_even = 64'sd10; in_odd = 64'sd11;
    tick();
    in_valid = 1'b0;
    tick();
    tests++; if (out_valid !== 1'b1 || out_data !== 16'sd10 || out_odd !== 1'b0) begin
      fails++; $display("FAIL flush_restart_even got v=%b d=%0d o=%b exp d=10 o=0", out_valid, out_data, out_odd); end
    tick();
    tests++; if (out_valid !== 1'b1 || out_data !== 16'sd11 || out_odd !== 1'b1) begin
      fails++; $display("FAIL flush_restart_odd got v=%b d=%0d o=%b exp d=11 o=1", out_valid, out_data, out_odd); end
    tick();
  endtask

  task automatic test_reset_midstream();
    int w;
    out_ready = 1'b1;
    in_valid = 1'b1; in_even = 64'sd300; in_odd = -64'sd300;
    tick();
    in_even = 64'sd400; in_odd = -64'sd400;
    tick();
    in_valid = 1'b0;
    w = 0;
    while (!(out_valid && out_odd) && w < 10) begin tick(); w++; end
    tests++; if (w >= 10) begin fails++; $display("FAIL mid_wait_odd got none exp odd within 10"); end
    rst = 1'b0;
    #1;
    exp_sat = 0;
    tests++; if (out_valid !== 1'b0 || out_data !== 16'sd0 || out_odd !== 1'b0) begin
      fails++; $display("FAIL mid_reset_out got v=%b d=%0d o=%b exp 0", out_valid, out_data, out_odd); end
    tests++; if (sat_count !== 16'd0 || in_ready !== 1'b0) begin
      fails++; $display("FAIL mid_reset_ctl got sat=%0d rdy=%b exp 0 0", sat_count, in_ready); end
    tick();
    rst = 1'b1;
    tick();
    tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++; $display("FAIL mid_release got rdy=%b v=%b exp 1 0", in_ready, out_valid); end
    in_valid = 1'b1; in_even = 64'sd7; in_odd = -64'sd7;
    tick();
    in_valid = 1'b0;
    tick();
    tests++; if (out_valid !== 1'b1 || out_data !== 16'sd7 || out_odd !== 1'b0) begin
      fails++; $display("FAIL mid_restart_even got v=%b d=%0d o=%b exp d=7 o=0", out_valid, out_data, out_odd); end
    tick();
    tests++; if (out_valid !== 1'b1 || out_data !== -16'sd7 || out_odd !== 1'b1) begin
      fails++; $display("FAIL mid_restart_odd got v=%b d=%0d o=%b exp d=-7 o=1", out_valid, out_data, out_odd); end
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_idle got=%b exp=0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_saturate();
    test_backpressure();
    test_full_pop_push();
    test_random();
    test_flush();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
